axis_uart_arbiter: RTL and testbench
====================================

# axis_uart_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream byte sink, the FIFO-fronted UART transmitter, between `NUM_SRC` AXI-Stream sources. A grant is held from the first beat of a packet through the beat carrying `last`, so packets from different sources never interleave on the serial line. A registered output stage drives the sink. An idle timeout frees the sink when a granted source stalls mid-packet.

## Interface
- `NUM_SRC`, 4: number of requesting sources, ≥2.
- `WIDTH`, 8: data width per beat.
- `TIMEOUT`, 4096: consecutive granted-but-idle cycles before a forced release; 0 disables the timeout.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `s_axis_data` in `NUM_SRC*WIDTH`: source i occupies bits [i*WIDTH +: WIDTH].
- `s_axis_valid` in `NUM_SRC`: per-source valid.
- `s_axis_last` in `NUM_SRC`: per-source end-of-packet.
- `s_axis_ready` out `NUM_SRC`: per-source ready; at most one bit high.
- `m_axis_data` out `WIDTH`: data to the FIFO/UART TX sink.
- `m_axis_valid` out 1: output beat valid.
- `m_axis_last` out 1: output beat is the last beat of its packet.
- `m_axis_ready` in 1: sink ready (the FIFO's not-full).
- `grant` out `NUM_SRC`: one-hot index of the current owner; all zero when idle.
- `busy` out 1: high while in LOCK.
- `timeout_err` out 1: one-cycle pulse on a forced release.

## Operation
- State machine: IDLE, LOCK.
- **IDLE**
  - `grant` is 0 and all `s_axis_ready` bits are 0.
  - If any `s_axis_valid` is high, the winner is the first requesting index scanning upward (with wrap) from `last_winner+1`.
  - The arbiter registers `grant`, the winner index and LOCK at the next edge.
- **LOCK**
  - `s_axis_ready[g] = !m_axis_valid || m_axis_ready`. All other ready bits are 0.
  - An input handshake (`s_axis_valid[g] && s_axis_ready[g]`) loads `m_axis_data` and `m_axis_last` from source g and sets `m_axis_valid`.
  - An output handshake with no input handshake in the same cycle clears `m_axis_valid`.
  - An input handshake with `s_axis_last[g]=1` returns the FSM to IDLE at the same edge and sets `last_winner <= g`.
- **Timeout** (`TIMEOUT>0`)
  - The idle counter is cleared on entry to LOCK and on every input handshake.
  - It increments on each LOCK cycle in which `s_axis_valid[g]=0`.
  - When the count reaches `TIMEOUT`: the FSM goes to IDLE, `last_winner <= g`, and `timeout_err` pulses for one cycle. No beat is emitted.
  - Counter width is `$clog2(TIMEOUT+1)`, with saturation.
- A grant holder that drops valid mid-packet keeps the lock until it sends `last` or the timeout fires.
- Requests from non-granted sources are ignored; their data is never sampled.
- The output stage is independent of the FSM. A beat held in the output register when the FSM leaves LOCK, by `last` or by timeout, is still delivered.
- Reset values:
  - outputs: `m_axis_valid`, `m_axis_last`, `m_axis_data`, `s_axis_ready`, `grant`, `busy`, `timeout_err` are all 0.
  - internal: state is IDLE and `last_winner = NUM_SRC-1`, so source 0 has first priority.
- Reset asserted mid-packet discards the partial packet and any held output beat immediately (asynchronous).

## Timing
- With a request seen in IDLE during cycle t:
  - `grant`/`busy` are high from t+1 and `s_axis_ready[g]` is high in t+1 if the output register is empty.
  - The first beat appears on `m_axis_valid` in t+2.
- Steady state: one beat per cycle while `m_axis_ready` is held high.
- Backpressure: while `m_axis_valid && !m_axis_ready`, `m_axis_data` and `m_axis_last` are held stable and `s_axis_ready[g]=0`.
- When the last beat is accepted at edge e:
  - IDLE holds during cycle e, the next grant is visible in e+1, and the next packet's first input handshake is at the end of cycle e+1 at the earliest.
  - Minimum inter-packet gap at the inputs is one dead cycle.
- `timeout_err` is high for exactly the cycle following the expiring edge. `busy` and `grant` are 0 in that same cycle.

## Test plan
- **Single source:** source 2 sends 3 beats 0x11, 0x22, 0x33 (last on 0x33), with `m_axis_ready=1`.
  - Required: grant=0b0100 one cycle after the request.
  - Required: output 0x11, 0x22, 0x33 on consecutive cycles, `m_axis_last` on 0x33 only, then grant=0.
- **Round-robin:** all four sources continuously request 2-beat packets.
  - Required: grant order 0, 1, 2, 3, 0, with no interleaving of beats within a packet.
- **Backpressure:** `m_axis_ready=0` for 5 cycles mid-packet (sink full).
  - Required: `m_axis_data` held stable and `s_axis_ready` low throughout.
  - Required: the packet resumes with no loss or duplication once ready returns.
- **Timeout:** `TIMEOUT=8`; source 1 sends one non-last beat, then drops valid while source 3 requests.
  - Required: `timeout_err` pulses 8 cycles after the stall, then grant=0b1000.
  - Required: source 1's beat is still delivered on the output.
- **Single-beat packets and async reset:**
  - Sources 0 and 1 each send 1-beat packets (valid and last together). Required: each takes one lock period, one beat per packet.
  - Reset asserted mid-packet. Required: all outputs 0 immediately, and after release source 0 is the first source granted.

Source files
------------

// File: rtl/axis_uart_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream byte sink (UART TX FIFO)
// between NUM_SRC sources, with a registered output stage and an idle timeout.
module axis_uart_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_SRC*WIDTH-1:0] s_axis_data,
  input  logic [NUM_SRC-1:0]       s_axis_valid,
  input  logic [NUM_SRC-1:0]       s_axis_last,
  output logic [NUM_SRC-1:0]       s_axis_ready,
  output logic [WIDTH-1:0]         m_axis_data,
  output logic                     m_axis_valid,
  output logic                     m_axis_last,
  input  logic                     m_axis_ready,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     busy,
  output logic                     timeout_err
);
  // Handshake rule on both sides: a beat moves on a rising edge where valid && ready
  // are both high; a source holds data/last stable while valid is high and not accepted.

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [IDX_W-1:0] last_winner_q, last_winner_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             terr_q, terr_d;
  logic [WIDTH-1:0] mdata_q, mdata_d;
  logic             mlast_q, mlast_d;
  logic             mvalid_q, mvalid_d;

  logic             req_any;
  logic [IDX_W-1:0] winner;
  logic             src_valid;
  logic             src_last;
  logic [WIDTH-1:0] src_data;
  logic             in_hs;
  logic [CNT_W-1:0] cnt_inc;
  logic             expire;

  // First requester scanning upward from last_winner+1 with wrap.
  always_comb begin
    req_any = 1'b0;
    winner  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (!req_any && s_axis_valid[j] && (j == ((int'(last_winner_q) + k) % NUM_SRC))) begin
          req_any = 1'b1;
          winner  = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    src_valid = 1'b0;
    src_last  = 1'b0;
    src_data  = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      if (gidx_q == IDX_W'(j)) begin
        src_valid = s_axis_valid[j];
        src_last  = s_axis_last[j];
        src_data  = s_axis_data[j*WIDTH +: WIDTH];
      end
    end
    in_hs = (state_q == ST_LOCK) && src_valid && (!mvalid_q || m_axis_ready);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      gidx_q        <= '0;
      last_winner_q <= LAST_IDX;
      idle_cnt_q    <= '0;
      terr_q        <= 1'b0;
      mdata_q       <= '0;
      mlast_q       <= 1'b0;
      mvalid_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      last_winner_q <= last_winner_d;
      idle_cnt_q    <= idle_cnt_d;
      terr_q        <= terr_d;
      mdata_q       <= mdata_d;
      mlast_q       <= mlast_d;
      mvalid_q      <= mvalid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    last_winner_d = last_winner_q;
    idle_cnt_d    = idle_cnt_q;
    terr_d        = 1'b0;
    cnt_inc       = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
    expire        = (TIMEOUT > 0) && !src_valid && (cnt_inc == CNT_MAX);
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          state_d    = ST_LOCK;
          gidx_d     = winner;
          idle_cnt_d = '0;
        end
      end
      ST_LOCK: begin
        if (in_hs) begin
          idle_cnt_d = '0;
          if (src_last) begin
            state_d       = ST_IDLE;
            last_winner_d = gidx_q;
          end
        end else if (!src_valid) begin
          // A stalled owner is dropped without emitting anything further.
          if (expire) begin
            state_d       = ST_IDLE;
            last_winner_d = gidx_q;
            terr_d        = 1'b1;
          end else if (TIMEOUT > 0) begin
            idle_cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output register runs independently of the FSM so a held beat survives a release.
  always_comb begin
    mdata_d  = mdata_q;
    mlast_d  = mlast_q;
    mvalid_d = mvalid_q;
    if (in_hs) begin
      mdata_d  = src_data;
      mlast_d  = src_last;
      mvalid_d = 1'b1;
    end else if (m_axis_ready) begin
      mvalid_d = 1'b0;
    end
  end

  always_comb begin
    s_axis_ready = '0;
    grant        = '0;
    busy         = (state_q == ST_LOCK);
    if (state_q == ST_LOCK) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (gidx_q == IDX_W'(j)) begin
          s_axis_ready[j] = !mvalid_q || m_axis_ready;
          grant[j]        = 1'b1;
        end
      end
    end
  end

  assign m_axis_data  = mdata_q;
  assign m_axis_last  = mlast_q;
  assign m_axis_valid = mvalid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_axis_uart_arbiter.sv
// Scoreboard bench for axis_uart_arbiter: per-source expected beat queues, a monitor
// that matches delivered packets against them, plus directed timing scenarios.
`timescale 1ns/1ps
module tb_axis_uart_arbiter;
  localparam int NS = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NS*W-1:0] s_data  = '0;
  logic [NS-1:0]   s_valid = '0;
  logic [NS-1:0]   s_last  = '0;
  logic [NS-1:0]   s_ready;
  logic [W-1:0]    m_data;
  logic            m_valid;
  logic            m_last;
  logic            m_ready = 1'b1;
  logic [NS-1:0]   grant;
  logic            busy;
  logic            timeout_err;

  axis_uart_arbiter #(.NUM_SRC(NS), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_data  (s_data),
    .s_axis_valid (s_valid),
    .s_axis_last  (s_last),
    .s_axis_ready (s_ready),
    .m_axis_data  (m_data),
    .m_axis_valid (m_valid),
    .m_axis_last  (m_last),
    .m_axis_ready (m_ready),
    .grant        (grant),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [W:0]  send_q [NS][$];   // beats still to offer, {last, data}
  logic [W:0]  exp_q  [NS][$];   // beats still to be seen at the sink
  int          pkt_order[$];
  logic [NS-1:0] in_hs = '0;
  int          gap [NS];
  bit          gaps_en = 1'b0;
  bit          rdy_rand = 1'b0;
  logic        rdy_force = 1'b1;
  bit          cur_active = 1'b0;
  int          cur_src = 0;
  logic [5:0]  seq [NS];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input int src, input logic [W-1:0] data, input logic last);
    send_q[src].push_back({last, data});
    exp_q[src].push_back({last, data});
  endtask

  // ---------------- driver ----------------
  // Inputs change on the falling edge; handshakes are sampled 1 ns before the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < NS; i++) begin
      if (in_hs[i]) begin
        void'(send_q[i].pop_front());
        gap[i] = (gaps_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (send_q[i].size() > 0 && gap[i] == 0) begin
        s_valid[i]       = 1'b1;
        s_data[i*W +: W] = send_q[i][0][W-1:0];
        s_last[i]        = send_q[i][0][W];
      end else begin
        s_valid[i]       = 1'b0;
        s_data[i*W +: W] = W'($urandom);
        s_last[i]        = 1'($urandom);
      end
    end
    m_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
    #4;
    for (int i = 0; i < NS; i++) in_hs[i] = s_valid[i] && s_ready[i];
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    s_valid = '0;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout_err", timeout_err, 0);
    for (int i = 0; i < NS; i++) begin
      send_q[i].delete();
      exp_q[i].delete();
      gap[i] = 0;
    end
    in_hs = '0;
    cur_active = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic drain();
    int  n = 0;
    bit  done = 1'b0;
    while (!done && n < 2000) begin
      tick();
      n++;
      done = !m_valid && !busy;
      for (int i = 0; i < NS; i++)
        if (send_q[i].size() != 0 || exp_q[i].size() != 0) done = 1'b0;
    end
    check("drain_done", done, 1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W:0] beat;
    int         hit;
    #4;
    if (rst) begin
      check("ready_onehot0", 32'($countones(s_ready) <= 1), 1);
      if (m_valid && m_ready) begin
        beat = {m_last, m_data};
        if (!cur_active) begin
          hit = -1;
          for (int i = 0; i < NS; i++)
            if (hit < 0 && exp_q[i].size() > 0 && exp_q[i][0] == beat) hit = i;
          if (hit < 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pkt_start: got 0x%0h, expected the head beat of some queued packet", beat);
          end else begin
            cur_src    = hit;
            cur_active = 1'b1;
            pkt_order.push_back(hit);
          end
        end
        if (cur_active) begin
          if (exp_q[cur_src].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_overrun: got 0x%0h, expected no further beat from source %0d", beat, cur_src);
            cur_active = 1'b0;
          end else begin
            check("beat", beat, exp_q[cur_src].pop_front());
            if (m_last) cur_active = 1'b0;
          end
        end
      end
      // An abandoned packet never sends last; the next beat starts a fresh packet.
      if (timeout_err) cur_active = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int s;
    int len;
    logic [W-1:0] held;
    int exp_grant [5];
    int exp_mv [5];

    for (int i = 0; i < NS; i++) begin
      gap[i] = 0;
      seq[i] = '0;
    end
    do_reset();

    // Single source: 3-beat packet from source 2 with sink always ready.
    rdy_force = 1'b1;
    push_beat(2, 8'h11, 1'b0);
    push_beat(2, 8'h22, 1'b0);
    push_beat(2, 8'h33, 1'b1);
    tick();
    check("t1_req_cycle_grant", grant, 4'b0000);
    tick();
    check("t1_grant", grant, 4'b0100);
    check("t1_busy", busy, 1);
    check("t1_ready", s_ready, 4'b0100);
    tick();
    check("t1_b0_valid", m_valid, 1);
    check("t1_b0_data", m_data, 8'h11);
    check("t1_b0_last", m_last, 0);
    tick();
    check("t1_b1_data", m_data, 8'h22);
    check("t1_b1_last", m_last, 0);
    tick();
    check("t1_b2_data", m_data, 8'h33);
    check("t1_b2_last", m_last, 1);
    check("t1_grant_after", grant, 4'b0000);
    drain();

    // Backpressure: sink full for 5 cycles in the middle of a 6-beat packet.
    for (int k = 0; k < 6; k++) push_beat(0, 8'hB0 + 8'(k), k == 5);
    repeat (4) tick();
    rdy_force = 1'b0;
    held = 8'hB2;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", m_valid, 1);
      check("bp_data", m_data, held);
      check("bp_last", m_last, 0);
      check("bp_s_ready", s_ready, 4'b0000);
    end
    rdy_force = 1'b1;
    tick();
    check("bp_resume_data", m_data, held);
    drain();

    // Round-robin: all four sources request 2-beat packets at once.
    do_reset();
    pkt_order.delete();
    push_beat(0, 8'h01, 1'b0); push_beat(0, 8'h02, 1'b1);
    push_beat(0, 8'h05, 1'b0); push_beat(0, 8'h06, 1'b1);
    push_beat(1, 8'h11, 1'b0); push_beat(1, 8'h12, 1'b1);
    push_beat(2, 8'h21, 1'b0); push_beat(2, 8'h22, 1'b1);
    push_beat(3, 8'h31, 1'b0); push_beat(3, 8'h32, 1'b1);
    drain();
    check("rr_count", pkt_order.size(), 5);
    if (pkt_order.size() == 5) begin
      check("rr_order0", pkt_order[0], 0);
      check("rr_order1", pkt_order[1], 1);
      check("rr_order2", pkt_order[2], 2);
      check("rr_order3", pkt_order[3], 3);
      check("rr_order4", pkt_order[4], 0);
    end

    // Single-beat packets from sources 0 and 1: one lock period each.
    do_reset();
    push_beat(0, 8'h40, 1'b1);
    push_beat(1, 8'h41, 1'b1);
    exp_grant = '{0, 1, 0, 2, 0};
    exp_mv    = '{0, 0, 1, 0, 1};
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sb_grant", grant, exp_grant[k]);
      check("sb_m_valid", m_valid, exp_mv[k]);
    end
    drain();

    // Asynchronous reset in the middle of a packet.
    for (int k = 0; k < 4; k++) push_beat(3, 8'h50 + 8'(k), k == 3);
    repeat (4) tick();
    check("mid_pkt_busy", busy, 1);
    do_reset();
    push_beat(1, 8'h61, 1'b1);
    push_beat(3, 8'h71, 1'b1);
    push_beat(0, 8'h60, 1'b1);
    tick();
    tick();
    check("post_rst_first_grant", grant, 4'b0001);
    drain();

    // Timeout: source 1 stalls after one non-last beat while source 3 waits.
    push_beat(1, 8'hA1, 1'b0);
    tick();
    tick();
    check("to_grant1", grant, 4'b0010);
    check("to_hs", in_hs, 4'b0010);
    push_beat(3, 8'hC1, 1'b0);
    push_beat(3, 8'hC2, 1'b1);
    n = 0;
    while (!timeout_err && n < 20) begin
      tick();
      n++;
    end
    check("to_stall_cycles", n - 1, TO);
    check("to_err_grant", grant, 4'b0000);
    check("to_err_busy", busy, 0);
    tick();
    check("to_err_pulse_width", timeout_err, 0);
    check("to_next_grant", grant, 4'b1000);
    check("to_src1_beat_delivered", exp_q[1].size(), 0);
    drain();

    // Randomized traffic with source gaps and random sink backpressure.
    gaps_en  = 1'b1;
    rdy_rand = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = int'($urandom_range(0, NS - 1));
        if (send_q[s].size() < 8) begin
          len = int'($urandom_range(1, 5));
          for (int b = 0; b < len; b++) begin
            push_beat(s, {2'(s), seq[s]}, b == len - 1);
            seq[s] = seq[s] + 6'd1;
          end
        end
      end
      tick();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
